// File: rtl/sysarr_stream.sv
// sysarr_stream: parametrised NxN output-stationary systolic matrix multiply.
// Computes C = A*B or C += A*B for signed integers. A is NxK and B is KxN.
// The caller streams one unskewed column of A and one row of B per beat.
// The engine skews both internally, flushes the array, then returns one row
// of C per valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready   input beat handshake
//   a_col, b_row          A[i][k] and B[k][j]; element i is at bits [i*DATA_W +: DATA_W]
//   in_last               marks the final k of the matrix
//   in_accum              first beat only: 1 keeps C, 0 clears C
//   out_valid / out_ready output row handshake
//   out_row, out_idx      C[out_idx][*]; element j is at bits [j*ACC_W +: ACC_W]
//   busy                  engine is not idle

// One processing element. It multiply-accumulates the values on its a/b inputs.
// The forwarding registers live in the parent module, so the edge PEs leave
// no output unconnected.
module sysarr_pe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_d, acc_q;

  // The full-width signed product is sign-extended to ACC_W.
  // The add wraps modulo 2^ACC_W.
  always_comb begin
    prod  = a_in * b_in;
    acc_d = clr ? '0 : acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

module sysarr_stream #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DATA_W-1:0]    a_col,
  input  logic [N*DATA_W-1:0]    b_row,
  input  logic                   in_last,
  input  logic                   in_accum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*ACC_W-1:0]     out_row,
  output logic [$clog2(N)-1:0]   out_idx,
  output logic                   busy
);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(2*N);
  localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(2*N-1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N-1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [IDX_W-1:0] out_idx_d, out_idx_q;
  logic             in_fire, clr;

  assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign out_idx   = out_idx_q;
  assign in_fire   = in_valid && in_ready;
  // Clearing happens only on the first beat of a matrix.
  // in_accum is ignored on every later beat.
  assign clr       = in_fire && (state_q == IDLE) && !in_accum;

  // ---------------- control FSM ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_idx_d = out_idx_q;
    case (state_q)
      IDLE, LOAD: begin
        if (in_fire) begin
          state_d = in_last ? FLUSH : LOAD;
          if (in_last) cnt_d = FLUSH_CNT;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d   = DRAIN;
          out_idx_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (out_idx_q == LAST_IDX) begin
            state_d   = IDLE;
            out_idx_d = '0;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_idx_q <= out_idx_d;
    end
  end

  // ---------------- input capture ----------------
  // Cycles without an accepted beat load zeros.
  // This makes bubbles, FLUSH and DRAIN contribute nothing to the accumulators.
  logic signed [DATA_W-1:0] in_a_d [N], in_a_q [N];
  logic signed [DATA_W-1:0] in_b_d [N], in_b_q [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_a_d[i] = in_fire ? a_col[i*DATA_W +: DATA_W] : '0;
      in_b_d[i] = in_fire ? b_row[i*DATA_W +: DATA_W] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        in_a_q[i] <= '0;
        in_b_q[i] <= '0;
      end
    end else begin
      in_a_q <= in_a_d;
      in_b_q <= in_b_d;
    end
  end

  // ---------------- skew ----------------
  // Lane i (row i of A, column i of B) is delayed i extra cycles.
  // As a result, A[i][k] and B[k][j] meet in PE(i,j) on the same cycle.
  logic signed [DATA_W-1:0] a_skew [N], b_skew [N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_nodl
      assign a_skew[i] = in_a_q[i];
      assign b_skew[i] = in_b_q[i];
    end else begin : g_dl
      logic signed [DATA_W-1:0] a_dl_d [i], a_dl_q [i];
      logic signed [DATA_W-1:0] b_dl_d [i], b_dl_q [i];
      always_comb begin
        a_dl_d[0] = in_a_q[i];
        b_dl_d[0] = in_b_q[i];
        for (int d = 1; d < i; d++) begin
          a_dl_d[d] = a_dl_q[d-1];
          b_dl_d[d] = b_dl_q[d-1];
        end
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < i; d++) begin
            a_dl_q[d] <= '0;
            b_dl_q[d] <= '0;
          end
        end else begin
          a_dl_q <= a_dl_d;
          b_dl_q <= b_dl_d;
        end
      end
      assign a_skew[i] = a_dl_q[i-1];
      assign b_skew[i] = b_dl_q[i-1];
    end
  end

  // ---------------- PE array ----------------
  // a moves right through a_pp_q and b moves down through b_pp_q.
  // Each hop takes one cycle.
  logic signed [DATA_W-1:0] a_pe   [N][N];
  logic signed [DATA_W-1:0] b_pe   [N][N];
  logic signed [ACC_W-1:0]  acc_pe [N][N];
  logic signed [DATA_W-1:0] a_pp_d [N][N-1], a_pp_q [N][N-1];
  logic signed [DATA_W-1:0] b_pp_d [N-1][N], b_pp_q [N-1][N];

  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      if (j == 0) begin : g_aw
        assign a_pe[i][j] = a_skew[i];
      end else begin : g_ai
        assign a_pe[i][j] = a_pp_q[i][j-1];
      end
      if (i == 0) begin : g_bn
        assign b_pe[i][j] = b_skew[j];
      end else begin : g_bi
        assign b_pe[i][j] = b_pp_q[i-1][j];
      end
      sysarr_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .a_in  (a_pe[i][j]),
        .b_in  (b_pe[i][j]),
        .acc   (acc_pe[i][j])
      );
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N-1; j++) a_pp_d[i][j] = a_pe[i][j];
    for (int i = 0; i < N-1; i++)
      for (int j = 0; j < N; j++) b_pp_d[i][j] = b_pe[i][j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N-1; j++) a_pp_q[i][j] <= '0;
      for (int i = 0; i < N-1; i++)
        for (int j = 0; j < N; j++) b_pp_q[i][j] <= '0;
    end else begin
      a_pp_q <= a_pp_d;
      b_pp_q <= b_pp_d;
    end
  end

  // ---------------- output ----------------
  // During DRAIN the inputs are all zero, so the accumulators are stable.
  // The row mux therefore holds steady under backpressure.
  always_comb begin
    out_row = '0;
    for (int j = 0; j < N; j++) out_row[j*ACC_W +: ACC_W] = acc_pe[out_idx_q][j];
  end
endmodule

// File: tb/tb_sysarr_stream.sv
module tb_sysarr_stream;
  localparam int N = 4, DW = 16, AW = 40, KMAX = 8;

  logic              clk = 0, rst_n = 0;
  logic              in_valid = 0, in_last = 0, in_accum = 0, out_ready = 0;
  logic [N*DW-1:0]   a_col = '0, b_row = '0;
  logic              in_ready, out_valid, busy;
  logic [N*AW-1:0]   out_row;
  logic [1:0]        out_idx;

  sysarr_stream #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row), .in_last(in_last), .in_accum(in_accum),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_idx(out_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [N*AW-1:0] row; logic [1:0] idx; } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  logic signed [DW-1:0] ma [N][KMAX];
  logic signed [DW-1:0] mb [KMAX][N];
  logic signed [AW-1:0] mc [N][N];

  task set_mats(input int av, input int bv, input bit ident, input bit rnd);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        ma[i][k] = rnd ? DW'($urandom) : ident ? DW'(i == k) : DW'(av);
        mb[k][i] = rnd ? DW'($urandom) : ident ? DW'(i == k) : DW'(bv);
      end
  endtask

  // Streams k beats and updates the reference C.
  // A stop_after>0 abandons the matrix after that many beats and pushes no rows.
  task feed(input int k, input bit accum, input bit gaps, input int stop_after);
    exp_t e;
    if (!accum) for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mc[i][j] = '0;
    for (int kk = 0; kk < k; kk++) begin
      if (stop_after > 0 && kk == stop_after) return;
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = ma[i][kk];
        b_row[i*DW +: DW] = mb[kk][i];
      end
      in_valid = 1;
      in_last  = (kk == k-1);
      in_accum = (kk == 0) ? accum : ~accum;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          mc[i][j] = mc[i][j] + AW'(longint'(ma[i][kk]) * longint'(mb[kk][j]));
      in_valid = 0; in_last = 0; in_accum = 0;
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) e.row[j*AW +: AW] = mc[i][j];
      e.idx = 2'(i);
      sb.push_back(e);
    end
  endtask

  // Pops the scoreboard as rows transfer.
  // out_ready is held low for stall_cycles cycles while row stall_idx is presented.
  task drain(input int stall_idx, input int stall_cycles);
    exp_t e;
    logic [N*AW-1:0] hold_row;
    logic [1:0] hold_idx;
    int guard = 0, stalled = 0;
    while (sb.size() > 0 && guard < 200) begin
      if (out_valid) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready got %b want 0", in_ready); end
        if (int'(out_idx) == stall_idx && stalled < stall_cycles) begin
          out_ready = 0;
          if (stalled == 0) begin hold_row = out_row; hold_idx = out_idx; end
          else begin
            checks++;
            if (out_row !== hold_row || out_idx !== hold_idx || busy !== 1'b1) begin
              errors++;
              $display("FAIL stall_hold row %h idx %0d busy %b want row %h idx %0d busy 1",
                       out_row, out_idx, busy, hold_row, hold_idx);
            end
          end
          stalled++;
        end else begin
          out_ready = 1;
          e = sb.pop_front();
          checks++;
          if (out_row !== e.row) begin errors++; $display("FAIL row%0d got %h want %h", e.idx, out_row, e.row); end
          checks++;
          if (out_idx !== e.idx) begin errors++; $display("FAIL out_idx got %0d want %0d", out_idx, e.idx); end
        end
      end else out_ready = 0;
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 0;
    checks++;
    if (guard >= 200) begin errors++; $display("FAIL drain_timeout remaining %0d rows want 0", sb.size()); sb.delete(); end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_drain in_ready %b out_valid %b busy %b want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task test_reset;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_row !== '0 || out_idx !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset in_ready %b out_valid %b out_row %h idx %0d busy %b want 1 0 0 0 0",
               in_ready, out_valid, out_row, out_idx, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task test_identity;
    set_mats(0, 0, 1, 0);
    feed(4, 0, 0, 0);
    drain(-1, 0);
  endtask

  // Input offered during FLUSH/DRAIN must be ignored.
  task test_latency;
    set_mats(1, 1, 0, 0);
    feed(4, 0, 0, 0);
    in_valid = 1; in_last = 1;
    a_col = {N{16'h7fff}}; b_row = {N{16'h7fff}};
    for (int c = 1; c <= 2*N; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== (c == 2*N) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL latency cycle %0d out_valid %b in_ready %b want %b 0", c, out_valid, in_ready, c == 2*N);
      end
    end
    drain(-1, 0);
    in_valid = 0; in_last = 0;
  endtask

  task test_accum;
    set_mats(1, 1, 0, 0);
    feed(4, 1, 0, 0);
    drain(-1, 0);
    feed(4, 0, 0, 0);
    drain(-1, 0);
  endtask

  task test_backpressure;
    set_mats(1, 1, 0, 0);
    feed(4, 0, 0, 0);
    drain(1, 5);
  endtask

  task test_gaps;
    set_mats(-3, 5, 0, 0);
    feed(3, 0, 0, 0);
    drain(-1, 0);
    feed(3, 0, 1, 0);
    drain(-1, 0);
  endtask

  task test_random;
    set_mats(0, 0, 0, 1);
    feed(6, 0, 1, 0);
    drain(2, 3);
    set_mats(0, 0, 0, 1);
    feed(1, 1, 0, 0);
    drain(-1, 0);
  endtask

  task test_reset_mid;
    set_mats(1, 1, 0, 0);
    feed(4, 0, 0, 2);
    rst_n = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_row !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid in_ready %b out_valid %b out_row %h busy %b want 1 0 0 0",
               in_ready, out_valid, out_row, busy);
    end
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    test_identity();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_latency();
    test_accum();
    test_backpressure();
    test_gaps();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
